// File: rtl/food_eat_tracker_if.sv
// Map ROM read port and food RAM port-A bundle between the tracker (master)
// and the memories (slave).
interface food_eat_tracker_if #(
    parameter int COLS = 80
);
    logic [5:0]      rom_addr;
    logic [COLS-1:0] rom_data;
    logic [5:0]      mem_addr;
    logic            mem_wr_en;
    logic [COLS-1:0] mem_wdata;
    logic [COLS-1:0] mem_rdata;

    modport master (
        output rom_addr, mem_addr, mem_wr_en, mem_wdata,
        input  rom_data, mem_rdata
    );

    modport slave (
        input  rom_addr, mem_addr, mem_wr_en, mem_wdata,
        output rom_data, mem_rdata
    );
endinterface

// File: rtl/food_eat_tracker.sv
// Copies the map ROM into the food RAM, then clears pellets under pacman on
// each game tick via read-modify-write, tracking score and pellets left.
//
// state | meaning
// INIT  | pipelined ROM->RAM copy, counting pellets
// IDLE  | ready, waiting for an in-range tick
// RD    | RAM row address driven
// CAP   | RAM row captured into row_buf
// UPD   | clear eaten pellet and update counters
module food_eat_tracker #(
    parameter int TILE_SHIFT = 4,
    parameter int MAP_ROWS   = 50,
    parameter int MAP_COLS   = 80,
    parameter int SCORE_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 restart,
    input  logic [10:0]          pacman_curr_pos_x,
    input  logic [9:0]           pacman_curr_pos_y,
    food_eat_tracker_if.master   bus,
    output logic                 ready,
    output logic                 eat_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [11:0]          food_left,
    output logic                 level_clear
);
    localparam logic [2:0] INIT = 3'd0;
    localparam logic [2:0] IDLE = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] UPD  = 3'd4;

    localparam logic [5:0]          ROWS6   = 6'(MAP_ROWS);
    localparam logic [9:0]          ROWS10  = 10'(MAP_ROWS);
    localparam logic [10:0]         COLS11  = 11'(MAP_COLS);
    localparam logic [MAP_COLS-1:0] ONE_HOT = MAP_COLS'(1);
    localparam logic [SCORE_W-1:0]  SCORE_MAX = {SCORE_W{1'b1}};

    logic [2:0]          state;
    logic [5:0]          cnt;
    logic [6:0]          col_q;
    logic [5:0]          row_q;
    logic [MAP_COLS-1:0] row_buf;

    logic [10:0] col_full;
    logic [9:0]  row_full;
    logic        in_range;
    logic        hit;

    assign col_full = pacman_curr_pos_x >> TILE_SHIFT;
    assign row_full = pacman_curr_pos_y >> TILE_SHIFT;
    assign in_range = (col_full < COLS11) && (row_full < ROWS10);
    assign hit      = (state == UPD) && row_buf[col_q];

    assign eat_pulse   = hit;
    assign level_clear = ready && (food_left == 12'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            cnt       <= 6'd0;
            col_q     <= 7'd0;
            row_q     <= 6'd0;
            row_buf   <= '0;
            ready     <= 1'b0;
            score     <= '0;
            food_left <= 12'd0;
        end else if (restart) begin
            // score deliberately survives a restart
            state     <= INIT;
            cnt       <= 6'd0;
            ready     <= 1'b0;
            food_left <= 12'd0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt != 6'd0)
                        food_left <= food_left + 12'($countones(bus.rom_data));
                    if (cnt == ROWS6) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                IDLE: begin
                    if (tick && in_range) begin
                        col_q <= col_full[6:0];
                        row_q <= row_full[5:0];
                        state <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    row_buf <= bus.mem_rdata;
                    state   <= UPD;
                end
                UPD: begin
                    if (hit) begin
                        if (score != SCORE_MAX)
                            score <= score + SCORE_W'(1);
                        food_left <= food_left - 12'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

    always_comb begin
        bus.rom_addr  = 6'd0;
        bus.mem_addr  = 6'd0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wdata = '0;
        case (state)
            INIT: begin
                if (cnt < ROWS6)
                    bus.rom_addr = cnt;
                // write lags the ROM address by one cycle
                if (cnt != 6'd0) begin
                    bus.mem_addr  = cnt - 6'd1;
                    bus.mem_wr_en = 1'b1;
                    bus.mem_wdata = bus.rom_data;
                end
            end
            RD: bus.mem_addr = row_q;
            UPD: begin
                bus.mem_addr = row_q;
                if (hit) begin
                    bus.mem_wr_en = 1'b1;
                    bus.mem_wdata = row_buf & ~(ONE_HOT << col_q);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_food_eat_tracker.sv
// Directed bench for food_eat_tracker with behavioural map ROM and food RAM.
module tb_food_eat_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] pos_x = 11'd0;
    logic [9:0]  pos_y = 10'd0;
    logic        ready, eat_pulse, level_clear;
    logic [15:0] score;
    logic [11:0] food_left;

    logic [79:0] rom [64];
    logic [79:0] ram [64];
    int wr_count = 0;
    int act_count = 0;
    int checks = 0;
    int errors = 0;
    int n, w0, a0;

    localparam logic [79:0] BIT79 = 80'h8000_0000_0000_0000_0000;

    food_eat_tracker_if #(.COLS(80)) bus ();

    food_eat_tracker dut (
        .clk(clk), .rst(rst), .tick(tick), .restart(restart),
        .pacman_curr_pos_x(pos_x), .pacman_curr_pos_y(pos_y),
        .bus(bus), .ready(ready), .eat_pulse(eat_pulse), .score(score),
        .food_left(food_left), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 80'd0;
            ram[i] = 80'd0;
        end
        rom[0]  = 80'h1;
        rom[49] = BIT79;
    end

    always @(posedge clk) begin
        if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
        bus.rom_data  <= rom[bus.rom_addr];
        if (rst && bus.mem_wr_en) wr_count <= wr_count + 1;
        if (bus.mem_addr != 6'd0) act_count <= act_count + 1;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_at(input int x, input int y);
        tick  = 1'b1;
        pos_x = 11'(x);
        pos_y = 10'(y);
        step(1);
        tick = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 200) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 80'(ready), 80'd0);
        check({tag, "_eat"}, 80'(eat_pulse), 80'd0);
        check({tag, "_score"}, 80'(score), 80'd0);
        check({tag, "_food"}, 80'(food_left), 80'd0);
        check({tag, "_lclr"}, 80'(level_clear), 80'd0);
        check({tag, "_wren"}, 80'(bus.mem_wr_en), 80'd0);
        check({tag, "_maddr"}, 80'(bus.mem_addr), 80'd0);
        check({tag, "_raddr"}, 80'(bus.rom_addr), 80'd0);
    endtask

    initial begin
        step(3);
        check_zero_outputs("rst");
        rst = 1'b1;
        wait_ready(n);
        check("init_lat", 80'(n), 80'd51);
        check("init_food", 80'(food_left), 80'd2);
        check("init_row0", ram[0], 80'h1);
        check("init_row1", ram[1], 80'h0);
        check("init_row49", ram[49], BIT79);
        check("init_lclr", 80'(level_clear), 80'd0);

        // eat at (0,0)
        tick_at(0, 0);
        step(2);
        check("eat0_pulse", 80'(eat_pulse), 80'd1);
        check("eat0_wren", 80'(bus.mem_wr_en), 80'd1);
        check("eat0_addr", 80'(bus.mem_addr), 80'd0);
        check("eat0_wdata", bus.mem_wdata, 80'd0);
        step(1);
        check("eat0_score", 80'(score), 80'd1);
        check("eat0_food", 80'(food_left), 80'd1);
        check("eat0_ram", ram[0], 80'd0);
        check("eat0_pulse_off", 80'(eat_pulse), 80'd0);

        // same tile again: nothing to eat
        w0 = wr_count;
        tick_at(0, 0);
        step(2);
        check("again_pulse", 80'(eat_pulse), 80'd0);
        check("again_wren", 80'(bus.mem_wr_en), 80'd0);
        step(1);
        check("again_score", 80'(score), 80'd1);
        check("again_wr", 80'(wr_count), 80'(w0));

        // far corner: col 79, row 49
        tick_at(1279, 799);
        step(2);
        check("corner_pulse", 80'(eat_pulse), 80'd1);
        check("corner_addr", 80'(bus.mem_addr), 80'd49);
        check("corner_wdata", bus.mem_wdata, 80'd0);
        step(1);
        check("corner_score", 80'(score), 80'd2);
        check("corner_food", 80'(food_left), 80'd0);
        check("corner_lclr", 80'(level_clear), 80'd1);
        check("corner_ram", ram[49], 80'd0);

        // out-of-range positions
        w0 = wr_count;
        a0 = act_count;
        tick_at(1280, 80);
        step(5);
        tick_at(16, 800);
        step(5);
        check("oor_wr", 80'(wr_count), 80'(w0));
        check("oor_access", 80'(act_count), 80'(a0));
        check("oor_score", 80'(score), 80'd2);
        check("oor_food", 80'(food_left), 80'd0);

        // restart reloads the map, keeps the score
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("rs_ready", 80'(ready), 80'd0);
        check("rs_lclr", 80'(level_clear), 80'd0);
        wait_ready(n);
        check("rs_lat", 80'(n), 80'd51);
        check("rs_food", 80'(food_left), 80'd2);
        check("rs_score", 80'(score), 80'd2);
        check("rs_lclr2", 80'(level_clear), 80'd0);
        check("rs_row0", ram[0], 80'h1);
        check("rs_row49", ram[49], BIT79);

        // back-to-back ticks: second is dropped
        w0 = wr_count;
        tick_at(0, 0);
        tick = 1'b1;
        pos_x = 11'd1279;
        pos_y = 10'd799;
        step(1);
        tick = 1'b0;
        step(8);
        check("b2b_score", 80'(score), 80'd3);
        check("b2b_food", 80'(food_left), 80'd1);
        check("b2b_wr", 80'(wr_count), 80'(w0 + 1));
        check("b2b_row49", ram[49], BIT79);

        // tick during INIT is dropped
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(3);
        tick_at(0, 0);
        wait_ready(n);
        step(4);
        check("initk_food", 80'(food_left), 80'd2);
        check("initk_score", 80'(score), 80'd3);
        check("initk_row0", ram[0], 80'h1);

        // tick and restart together: restart wins
        tick = 1'b1;
        restart = 1'b1;
        pos_x = 11'd0;
        pos_y = 10'd0;
        step(1);
        tick = 1'b0;
        restart = 1'b0;
        check("tr_ready", 80'(ready), 80'd0);
        wait_ready(n);
        step(4);
        check("tr_score", 80'(score), 80'd3);
        check("tr_food", 80'(food_left), 80'd2);
        check("tr_row0", ram[0], 80'h1);

        // async reset during UPD write
        tick_at(0, 0);
        step(2);
        check("updrst_pre", 80'(eat_pulse), 80'd1);
        rst = 1'b0;
        #1;
        check_zero_outputs("updrst");
        step(2);
        rst = 1'b1;
        wait_ready(n);
        check("updrst_lat", 80'(n), 80'd51);
        check("updrst_food", 80'(food_left), 80'd2);
        check("updrst_row0", ram[0], 80'h1);

        // async reset mid-INIT
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(20);
        rst = 1'b0;
        #1;
        check_zero_outputs("initrst");
        step(1);
        rst = 1'b1;
        wait_ready(n);
        check("initrst_lat", 80'(n), 80'd51);
        check("initrst_food", 80'(food_left), 80'd2);
        check("initrst_row49", ram[49], BIT79);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/food_eat_tracker.md
# food_eat_tracker

Sits downstream of the pacman movement logic and upstream of the display's food-map read port. It owns the write side of the dual-port food RAM. After reset or restart it copies the static pacman map ROM into the food RAM and counts the food pellets. On each game tick it converts pacman's pixel position to a tile, does a read-modify-write of that RAM row, clears the eaten pellet, and maintains the score, pellets-left count and level-clear flag.

## Interface
Parameters:
- TILE_SHIFT, 4, pixel-to-tile shift (16-px tiles)
- MAP_ROWS, 50, rows in map/food RAM
- MAP_COLS, 80, bits per row
- SCORE_W, 16, score width

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle game-tick pulse in clk domain
- restart  input  1  one-cycle pulse: reload food RAM from ROM
- pacman_curr_pos_x  input  11  pacman pixel x
- pacman_curr_pos_y  input  10  pacman pixel y
- rom_addr  output  6  map ROM row address
- rom_data  input  80  map ROM row; valid the cycle after rom_addr
- mem_addr  output  6  food RAM port-A row address
- mem_wr_en  output  1  food RAM port-A write enable
- mem_wdata  output  80  food RAM port-A write data
- mem_rdata  input  80  food RAM port-A read data; valid the cycle after mem_addr
- ready  output  1  high when init is complete and ticks are accepted
- eat_pulse  output  1  one-cycle pulse per pellet eaten
- score  output  SCORE_W  pellets eaten since reset
- food_left  output  12  pellets remaining
- level_clear  output  1  high when ready and food_left==0

## Operation
- Tile mapping: col = pos_x >> TILE_SHIFT, row = pos_y >> TILE_SHIFT. The position is sampled on the tick cycle. Bit `col` of a row holds column col, with bit 0 = column 0.
- FSM states: INIT, IDLE, RD, CAP, UPD.
- INIT:
  - Pipelined copy. Cycle k drives rom_addr=k for k=0..MAP_ROWS-1.
  - Cycle k+1 drives mem_addr=k, mem_wr_en=1, mem_wdata=rom_data, and adds popcount(rom_data) to food_left.
  - After the write of row MAP_ROWS-1, go to IDLE and set ready=1.
  - food_left is cleared on entry to INIT.
- IDLE:
  - tick with col<MAP_COLS and row<MAP_ROWS: latch col/row, go to RD.
  - Out-of-range tick: ignored, no RAM access.
- RD: drive mem_addr=row, mem_wr_en=0. Go to CAP.
- CAP: register mem_rdata into row_buf. Go to UPD.
- UPD:
  - If row_buf[col]=1: mem_addr=row, mem_wr_en=1, mem_wdata=row_buf with bit col cleared; eat_pulse=1; score+1 (saturating at all-ones); food_left-1.
  - Otherwise no write.
  - Go to IDLE.
- restart in any state: abort the current operation and enter INIT with rom counter 0. ready falls on the next cycle. score is preserved.
- tick while not in IDLE, or while ready=0: dropped, not queued.
- tick and restart in the same cycle: restart wins.
- mem_wr_en is asserted only in INIT write cycles and UPD eat cycles.

## Timing
- Reset (rst low, asynchronous):
  - All outputs are 0: ready, eat_pulse, score, food_left, level_clear, mem_wr_en, addresses.
  - State is INIT, counter is 0.
  - The copy starts on the first clk edge after rst deasserts.
- Init latency: MAP_ROWS+1 cycles (51) from the first INIT cycle to ready=1.
- Tick to eat: tick at cycle T gives RD at T+1, CAP at T+2, UPD at T+3. eat_pulse and mem_wr_en are high during T+3; score/food_left update at the end of T+3.
- Minimum tick spacing for acceptance is 4 cycles.
- level_clear is combinational from registered ready and food_left. It is high from the cycle after the final eat until restart or reset.
- food_left never underflows, because a write only occurs when the bit is set.
- score wraps are impossible; it holds at 2^SCORE_W-1.

## Test plan
- ROM model with row 0 = 80'h1 and row 49 = 80'h8000_0000_0000_0000_0000 (bit 79), all other rows 0. Release reset -> ready rises exactly 51 cycles later, food_left=2, RAM row 0 = 80'h1, row 49 = 80'h8000_0000_0000_0000_0000.
- After init, tick with pos=(0,0) -> eat_pulse at T+3, RAM row 0 = 0, score=1, food_left=1. A second tick at the same position -> no eat_pulse, no write, score stays 1.
- Tick with pos=(1279,799) (col 79, row 49) -> bit 79 cleared, score=2, food_left=0, level_clear=1. Then pulse restart -> ready drops, food_left=2 after 51 cycles, score still 2, level_clear=0.
- Tick with pos_x=1280 (col 80) or pos_y=800 (row 50) -> no RAM access, nothing changes.
- Tick at T and T+1 -> only the first is processed. Tick during INIT -> dropped.
- Assert rst low during a UPD write and during mid-INIT -> all outputs are 0 immediately. After release, a full 51-cycle init occurs and food_left is recounted from the ROM.
